// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters; one op in flight.
// Optional macro ALU_ARB_ILLEGAL_OP_CHECK_EN flags unsupported opcodes via rsp_err.
module alu_share_arb #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1,
  parameter int unsigned DW   = 32,
  parameter int unsigned IW   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*IW-1:0] req_inst,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  output logic [IW-1:0]      alu_inst,
  output logic [DW-1:0]      alu_da,
  output logic [DW-1:0]      alu_db,
  input  logic [DW-1:0]      alu_out,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW-1:0]      rsp_data,
  output logic               rsp_err
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  localparam logic [IDW-1:0] LastId = IDW'(NREQ - 1);

  state_e         state_q;
  logic [IDW-1:0] ptr_q;

  logic            found;
  logic [IDW-1:0]  winner;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   sel_inst;
  logic [DW-1:0]   sel_a;
  logic [DW-1:0]   sel_b;

  // First pass covers ptr..NREQ-1, second pass wraps to 0..ptr-1.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    gnt      = '0;
    sel_inst = '0;
    sel_a    = '0;
    sel_b    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i] && (i >= int'(ptr_q))) begin
        found    = 1'b1;
        winner   = IDW'(i);
        gnt[i]   = 1'b1;
        sel_inst = req_inst[i*IW +: IW];
        sel_a    = req_a[i*DW +: DW];
        sel_b    = req_b[i*DW +: DW];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i]) begin
        found    = 1'b1;
        winner   = IDW'(i);
        gnt[i]   = 1'b1;
        sel_inst = req_inst[i*IW +: IW];
        sel_a    = req_a[i*DW +: DW];
        sel_b    = req_b[i*DW +: DW];
      end
    end
  end

  assign req_ready = (state_q == StIdle && !rst) ? gnt : '0;

`ifdef ALU_ARB_ILLEGAL_OP_CHECK_EN
  logic sel_legal;
  logic err_q;

  assign sel_legal = sel_inst inside {IW'(16'h0001), IW'(16'h0029), IW'(16'h0021),
                                      IW'(16'h0009), IW'(16'h0031)};
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      alu_inst  <= '0;
      alu_da    <= '0;
      alu_db    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
`ifdef ALU_ARB_ILLEGAL_OP_CHECK_EN
      err_q     <= 1'b0;
      rsp_err   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
`ifdef ALU_ARB_ILLEGAL_OP_CHECK_EN
            alu_inst <= sel_legal ? sel_inst : '0;
            err_q    <= !sel_legal;
`else
            alu_inst <= sel_inst;
`endif
            alu_da   <= sel_a;
            alu_db   <= sel_b;
            rsp_id   <= winner;
            ptr_q    <= (winner == LastId) ? '0 : winner + 1'b1;
            state_q  <= StExec;
          end
        end
        StExec: begin
          rsp_valid <= 1'b1;
`ifdef ALU_ARB_ILLEGAL_OP_CHECK_EN
          rsp_data  <= err_q ? '0 : alu_out;
          rsp_err   <= err_q;
`else
          rsp_data  <= alu_out;
`endif
          state_q   <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
